// File: rtl/ft_fifo_if.sv
// FT2232H synchronous 245-FIFO pin bundle plus the host-side byte streams.
// The responder (slave) drives status and read data; the FPGA/host side (master) drives strobes and pushes.
interface ft_fifo_if #(
    parameter int DW = 8
);
    logic          RXF;
    logic          TXE;
    logic          OE;
    logic          RD;
    logic          WR;
    logic [DW-1:0] DOUT;
    logic          DOUT_EN;
    logic [DW-1:0] DIN;
    logic          h_wr_valid;
    logic [DW-1:0] h_wr_data;
    logic          h_wr_ready;
    logic          h_rd_valid;
    logic [DW-1:0] h_rd_data;
    logic          h_rd_ready;

    modport slave (
        output RXF, TXE, DOUT, DOUT_EN, h_wr_ready, h_rd_valid, h_rd_data,
        input  OE, RD, WR, DIN, h_wr_valid, h_wr_data, h_rd_ready
    );

    modport master (
        input  RXF, TXE, DOUT, DOUT_EN, h_wr_ready, h_rd_valid, h_rd_data,
        output OE, RD, WR, DIN, h_wr_valid, h_wr_data, h_rd_ready
    );
endinterface

// File: rtl/ft_fifo_responder.sv
// Stand-in for the FT2232H sync 245-FIFO: an RX buffer the FPGA reads with RD/OE
// and a TX buffer the FPGA fills with WR, each fed/drained by a host byte stream.
module ft_fifo_responder #(
    parameter int DW       = 8,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16,
    localparam int RXAW    = $clog2(RX_DEPTH),
    localparam int TXAW    = $clog2(TX_DEPTH),
    localparam int RXCW    = RXAW + 1,
    localparam int TXCW    = TXAW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    ft_fifo_if.slave        bus,
    output logic [RXCW-1:0] rx_count,
    output logic [TXCW-1:0] tx_count,
    output logic            rd_err,
    output logic            wr_err
);
    logic [DW-1:0]   rx_mem_q [RX_DEPTH];
    logic [DW-1:0]   tx_mem_q [TX_DEPTH];

    logic [RXAW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [TXAW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [RXCW-1:0] rx_count_q, rx_count_d;
    logic [TXCW-1:0] tx_count_q, tx_count_d;
    logic            rxf_q, rxf_d, txe_q, txe_d;
    logic            h_wr_ready_q, h_wr_ready_d, h_rd_valid_q, h_rd_valid_d;
    logic            dout_en_q, dout_en_d;
    logic [DW-1:0]   dout_q, dout_d, h_rd_data_q, h_rd_data_d;
    logic            rd_err_q, rd_err_d, wr_err_q, wr_err_d;

    logic            rx_push_s, rx_pop_s, rd_bad_s;
    logic            tx_push_s, tx_pop_s, wr_bad_s;

    // Strobe qualification uses only pre-edge registered status, so flags and counts never disagree.
    always_comb begin
        rx_push_s = bus.h_wr_valid & h_wr_ready_q;
        rx_pop_s  = ~bus.RD & dout_en_q & ~rxf_q;
        rd_bad_s  = ~bus.RD & (rxf_q | ~dout_en_q);
        tx_push_s = ~bus.WR & ~txe_q;
        tx_pop_s  = h_rd_valid_q & bus.h_rd_ready;
        wr_bad_s  = ~bus.WR & txe_q;
    end

    // RX next state: pointers, occupancy, post-edge status and the head byte shown on DOUT.
    always_comb begin
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_count_d  = rx_count_q;
        if (rx_push_s) begin
            rx_wr_ptr_d = rx_wr_ptr_q + RXAW'(1'b1);
        end else begin
            rx_wr_ptr_d = rx_wr_ptr_q;
        end
        if (rx_pop_s) begin
            rx_rd_ptr_d = rx_rd_ptr_q + RXAW'(1'b1);
        end else begin
            rx_rd_ptr_d = rx_rd_ptr_q;
        end
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_count_d = rx_count_q + RXCW'(1'b1);
            2'b01:   rx_count_d = rx_count_q - RXCW'(1'b1);
            default: rx_count_d = rx_count_q;
        endcase
        rxf_d        = (rx_count_d == {RXCW{1'b0}});
        h_wr_ready_d = (rx_count_d < RXCW'(RX_DEPTH));
        dout_en_d    = ~bus.OE;
        // A byte pushed into the slot that becomes the head is not in the memory yet.
        if (rx_push_s && (rx_wr_ptr_q == rx_rd_ptr_d)) begin
            dout_d = bus.h_wr_data;
        end else begin
            dout_d = rx_mem_q[rx_rd_ptr_d];
        end
        rd_err_d = rd_err_q | rd_bad_s;
    end

    // TX next state: mirrors RX with the FPGA as producer and the host as consumer.
    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_count_d  = tx_count_q;
        if (tx_push_s) begin
            tx_wr_ptr_d = tx_wr_ptr_q + TXAW'(1'b1);
        end else begin
            tx_wr_ptr_d = tx_wr_ptr_q;
        end
        if (tx_pop_s) begin
            tx_rd_ptr_d = tx_rd_ptr_q + TXAW'(1'b1);
        end else begin
            tx_rd_ptr_d = tx_rd_ptr_q;
        end
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_count_d = tx_count_q + TXCW'(1'b1);
            2'b01:   tx_count_d = tx_count_q - TXCW'(1'b1);
            default: tx_count_d = tx_count_q;
        endcase
        txe_d        = (tx_count_d == TXCW'(TX_DEPTH));
        h_rd_valid_d = (tx_count_d != {TXCW{1'b0}});
        if (tx_push_s && (tx_wr_ptr_q == tx_rd_ptr_d)) begin
            h_rd_data_d = bus.DIN;
        end else begin
            h_rd_data_d = tx_mem_q[tx_rd_ptr_d];
        end
        wr_err_d = wr_err_q | wr_bad_s;
    end

    // Buffer storage; contents need no reset because pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (rx_push_s) begin
            rx_mem_q[rx_wr_ptr_q] <= bus.h_wr_data;
        end
        if (tx_push_s) begin
            tx_mem_q[tx_wr_ptr_q] <= bus.DIN;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr_q  <= {RXAW{1'b0}};
            rx_rd_ptr_q  <= {RXAW{1'b0}};
            tx_wr_ptr_q  <= {TXAW{1'b0}};
            tx_rd_ptr_q  <= {TXAW{1'b0}};
            rx_count_q   <= {RXCW{1'b0}};
            tx_count_q   <= {TXCW{1'b0}};
            rxf_q        <= 1'b1;
            txe_q        <= 1'b1;
            h_wr_ready_q <= 1'b0;
            h_rd_valid_q <= 1'b0;
            dout_en_q    <= 1'b0;
            dout_q       <= {DW{1'b0}};
            h_rd_data_q  <= {DW{1'b0}};
            rd_err_q     <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            rx_wr_ptr_q  <= rx_wr_ptr_d;
            rx_rd_ptr_q  <= rx_rd_ptr_d;
            tx_wr_ptr_q  <= tx_wr_ptr_d;
            tx_rd_ptr_q  <= tx_rd_ptr_d;
            rx_count_q   <= rx_count_d;
            tx_count_q   <= tx_count_d;
            rxf_q        <= rxf_d;
            txe_q        <= txe_d;
            h_wr_ready_q <= h_wr_ready_d;
            h_rd_valid_q <= h_rd_valid_d;
            dout_en_q    <= dout_en_d;
            dout_q       <= dout_d;
            h_rd_data_q  <= h_rd_data_d;
            rd_err_q     <= rd_err_d;
            wr_err_q     <= wr_err_d;
        end
    end

    assign bus.RXF        = rxf_q;
    assign bus.TXE        = txe_q;
    assign bus.DOUT       = dout_q;
    assign bus.DOUT_EN    = dout_en_q;
    assign bus.h_wr_ready = h_wr_ready_q;
    assign bus.h_rd_valid = h_rd_valid_q;
    assign bus.h_rd_data  = h_rd_data_q;
    assign rx_count       = rx_count_q;
    assign tx_count       = tx_count_q;
    assign rd_err         = rd_err_q;
    assign wr_err         = wr_err_q;
endmodule

// File: tb/tb_ft_fifo_responder.sv
// Directed bench for ft_fifo_responder: reset, RX read stream, TX fill/drain,
// pointer wrap with concurrent push/pop, protocol errors and full-duplex strobes.
module tb_ft_fifo_responder;
    logic       clk;
    logic       rst_n;
    logic [4:0] rx_count;
    logic [4:0] tx_count;
    logic       rd_err;
    logic       wr_err;
    int         tests_run;
    int         fails;

    ft_fifo_if #(.DW(8)) bus ();

    ft_fifo_responder #(.DW(8), .RX_DEPTH(16), .TX_DEPTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .rx_count (rx_count),
        .tx_count (tx_count),
        .rd_err   (rd_err),
        .wr_err   (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.OE         = 1'b1;
        bus.RD         = 1'b1;
        bus.WR         = 1'b1;
        bus.DIN        = 8'h00;
        bus.h_wr_valid = 1'b0;
        bus.h_wr_data  = 8'h00;
        bus.h_rd_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic push_rx(input logic [7:0] b);
        bus.h_wr_valid = 1'b1;
        bus.h_wr_data  = b;
        tick();
        bus.h_wr_valid = 1'b0;
    endtask

    task automatic wr_tx(input logic [7:0] b);
        bus.WR  = 1'b0;
        bus.DIN = b;
        tick();
        bus.WR  = 1'b1;
    endtask

    initial begin
        logic [7:0] exp3 [3];
        exp3      = '{8'h11, 8'h22, 8'h33};
        tests_run = 0;
        fails     = 0;
        rst_n     = 1'b1;
        idle_inputs();

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_rxf",        32'(bus.RXF), 32'h1);
        check_val("rst_txe",        32'(bus.TXE), 32'h1);
        check_val("rst_dout_en",    32'(bus.DOUT_EN), 32'h0);
        check_val("rst_dout",       32'(bus.DOUT), 32'h0);
        check_val("rst_h_wr_ready", 32'(bus.h_wr_ready), 32'h0);
        check_val("rst_h_rd_valid", 32'(bus.h_rd_valid), 32'h0);
        check_val("rst_h_rd_data",  32'(bus.h_rd_data), 32'h0);
        check_val("rst_rx_count",   32'(rx_count), 32'h0);
        check_val("rst_tx_count",   32'(tx_count), 32'h0);
        check_val("rst_rd_err",     32'(rd_err), 32'h0);
        check_val("rst_wr_err",     32'(wr_err), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check_val("rel_txe",        32'(bus.TXE), 32'h0);
        check_val("rel_h_wr_ready", 32'(bus.h_wr_ready), 32'h1);
        check_val("rel_rxf",        32'(bus.RXF), 32'h1);

        // Reset mid-operation with 3 bytes buffered
        push_rx(8'h11);
        check_val("push_rxf_low", 32'(bus.RXF), 32'h0);
        push_rx(8'h22);
        push_rx(8'h33);
        check_val("mid_rx_count_pre", 32'(rx_count), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rxf",        32'(bus.RXF), 32'h1);
        check_val("mid_txe",        32'(bus.TXE), 32'h1);
        check_val("mid_rx_count",   32'(rx_count), 32'h0);
        check_val("mid_dout",       32'(bus.DOUT), 32'h0);
        check_val("mid_h_wr_ready", 32'(bus.h_wr_ready), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check_val("mid_rel_txe",      32'(bus.TXE), 32'h0);
        check_val("mid_rel_rxf",      32'(bus.RXF), 32'h1);
        check_val("mid_rel_rx_count", 32'(rx_count), 32'h0);

        // Host->FPGA stream
        push_rx(8'h11);
        push_rx(8'h22);
        push_rx(8'h33);
        check_val("rx3_count", 32'(rx_count), 32'h3);
        bus.OE = 1'b0;
        check_val("oe_dout_en_before", 32'(bus.DOUT_EN), 32'h0);
        tick();
        check_val("oe_dout_en_after", 32'(bus.DOUT_EN), 32'h1);
        bus.RD = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_val("rx_stream_data", 32'(bus.DOUT), 32'(exp3[k]));
            tick();
        end
        bus.RD = 1'b1;
        check_val("rx_stream_rxf",    32'(bus.RXF), 32'h1);
        check_val("rx_stream_count",  32'(rx_count), 32'h0);
        check_val("rx_stream_rd_err", 32'(rd_err), 32'h0);
        bus.OE = 1'b1;
        tick();

        // FPGA->host fill to full, overflow, drain
        bus.WR = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.DIN = 8'(i);
            tick();
        end
        check_val("tx_full_txe",    32'(bus.TXE), 32'h1);
        check_val("tx_full_count",  32'(tx_count), 32'h10);
        check_val("tx_full_wr_err", 32'(wr_err), 32'h0);
        bus.DIN = 8'hAA;
        tick();
        bus.WR = 1'b1;
        check_val("tx_ovf_wr_err", 32'(wr_err), 32'h1);
        check_val("tx_ovf_count",  32'(tx_count), 32'h10);
        check_val("tx_h_rd_valid", 32'(bus.h_rd_valid), 32'h1);
        bus.h_rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_val("tx_drain_data", 32'(bus.h_rd_data), 32'(i));
            tick();
        end
        bus.h_rd_ready = 1'b0;
        check_val("tx_drained_valid", 32'(bus.h_rd_valid), 32'h0);
        check_val("tx_drained_count", 32'(tx_count), 32'h0);

        // Wrap with concurrent push/pop at 15/16
        do_reset();
        for (int i = 0; i < 15; i++) push_rx(8'(32'h80 + i));
        check_val("wrap_fill_count", 32'(rx_count), 32'hF);
        bus.OE = 1'b0;
        tick();
        bus.RD         = 1'b0;
        bus.h_wr_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bus.h_wr_data = 8'(32'h8F + k);
            check_val("wrap_data",     32'(bus.DOUT), 32'h80 + k);
            check_val("wrap_count",    32'(rx_count), 32'hF);
            check_val("wrap_wr_ready", 32'(bus.h_wr_ready), 32'h1);
            tick();
        end
        bus.RD         = 1'b1;
        bus.h_wr_valid = 1'b0;
        check_val("wrap_end_count",  32'(rx_count), 32'hF);
        check_val("wrap_end_rd_err", 32'(rd_err), 32'h0);
        bus.OE = 1'b1;
        tick();

        // Protocol violation: RD with OE high
        do_reset();
        push_rx(8'h5A);
        bus.RD = 1'b0;
        tick();
        bus.RD = 1'b1;
        check_val("viol_oe_rd_err", 32'(rd_err), 32'h1);
        check_val("viol_oe_count",  32'(rx_count), 32'h1);

        // Protocol violation: RD on empty buffer
        do_reset();
        check_val("viol_rst_rd_err", 32'(rd_err), 32'h0);
        bus.OE = 1'b0;
        tick();
        bus.RD = 1'b0;
        tick();
        bus.RD = 1'b1;
        check_val("viol_empty_rd_err", 32'(rd_err), 32'h1);
        check_val("viol_empty_count",  32'(rx_count), 32'h0);
        check_val("viol_empty_wr_err", 32'(wr_err), 32'h0);
        bus.OE = 1'b1;

        // Full-duplex RD and WR together
        do_reset();
        for (int i = 0; i < 10; i++) push_rx(8'(32'h40 + i));
        for (int i = 0; i < 4; i++) wr_tx(8'(32'hC0 + i));
        check_val("fd_rx_pre", 32'(rx_count), 32'hA);
        check_val("fd_tx_pre", 32'(tx_count), 32'h4);
        bus.OE = 1'b0;
        tick();
        bus.RD = 1'b0;
        bus.WR = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.DIN = 8'(32'hD0 + k);
            check_val("fd_rx_data", 32'(bus.DOUT), 32'h40 + k);
            tick();
        end
        bus.RD = 1'b1;
        bus.WR = 1'b1;
        bus.OE = 1'b1;
        check_val("fd_rx_count", 32'(rx_count), 32'h2);
        check_val("fd_tx_count", 32'(tx_count), 32'hC);
        check_val("fd_rd_err",   32'(rd_err), 32'h0);
        check_val("fd_wr_err",   32'(wr_err), 32'h0);
        bus.h_rd_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check_val("fd_tx_drain", 32'(bus.h_rd_data),
                      (i < 4) ? (32'hC0 + i) : (32'hD0 + i - 4));
            tick();
        end
        bus.h_rd_ready = 1'b0;
        check_val("fd_tx_empty", 32'(tx_count), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
